// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM states, default
// widths/limits and the error-cause encoding kept for debug.
package mem_stage_pkg;

    localparam int MEM_DW      = 16;
    localparam int MEM_TIMEOUT = 15;
    localparam int MEM_CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_CONFLICT = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_cause_e;

    // Word-addressed memory: any address with bit 0 set is misaligned.
    function automatic logic addr_misaligned(input logic addr_lsb);
        return addr_lsb;
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Wait-cycle counter for the memory handshake. expire_o flags the cycle in
// which the count would reach TIMEOUT while counting is enabled.
module mem_wait_ctr #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_q + CNT_W'(1);
    assign expire_o  = en_i && (cnt_inc_s == CNT_W'(TIMEOUT));

    // Next count: clear wins over enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access stage: turns an execute result into a data-memory
// request/done handshake (or a pass-through), stalls the front end while
// busy and returns the writeback value. Misaligned, conflicting and
// timed-out accesses park the stage in a sticky error state.
module mem_access_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DW      = MEM_DW,
    parameter int TIMEOUT = MEM_TIMEOUT,
    parameter int CNT_W   = MEM_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_out,
    input  logic [DW-1:0] st_data,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic          halt,
    output logic [DW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          dm_en,
    output logic          dm_wr,
    input  logic [DW-1:0] dm_rdata,
    input  logic          dm_stall,
    input  logic          dm_done,
    output logic [DW-1:0] mem_out,
    output logic          mem_valid,
    output logic          mem_busy,
    output logic          mem_err,
    output logic          halted
);

    state_e     state_q,     state_d;
    err_cause_e err_cause_q, err_cause_d;

    logic [DW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic          wr_q,      wr_d;
    logic [DW-1:0] mem_out_q, mem_out_d;

    logic dm_en_q,     dm_en_d;
    logic dm_wr_q,     dm_wr_d;
    logic mem_valid_q, mem_valid_d;
    logic mem_busy_q,  mem_busy_d;
    logic mem_err_q,   mem_err_d;
    logic halted_q,    halted_d;

    logic ctr_clr_s;
    logic ctr_en_s;
    logic ctr_expire_s;
    logic is_mem_op_s;

    // The counter only runs in WAIT and restarts from zero on every entry.
    assign ctr_en_s    = (state_q == ST_WAIT);
    assign ctr_clr_s   = (state_q != ST_WAIT);
    assign is_mem_op_s = mem_rd || mem_wr;

    mem_wait_ctr #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (ctr_clr_s),
        .en_i     (ctr_en_s),
        .expire_o (ctr_expire_s)
    );

    // Next-state, captured operands and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        err_cause_d = err_cause_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        mem_out_d   = mem_out_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (halt) begin
                        state_d = ST_HALT;
                    end else if (mem_rd && mem_wr) begin
                        state_d     = ST_ERR;
                        err_cause_d = ERR_CONFLICT;
                    end else if (is_mem_op_s && addr_misaligned(ex_out[0])) begin
                        state_d     = ST_ERR;
                        err_cause_d = ERR_MISALIGN;
                    end else if (is_mem_op_s) begin
                        addr_d  = ex_out;
                        wdata_d = st_data;
                        wr_d    = mem_wr;
                        state_d = ST_REQ;
                    end else begin
                        mem_out_d = ex_out;
                        state_d   = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dm_stall) begin
                    state_d = ST_REQ;
                end else if (dm_done) begin
                    if (!wr_q) begin
                        mem_out_d = dm_rdata;
                    end else begin
                        mem_out_d = mem_out_q;
                    end
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion on the last count cycle still wins.
                if (dm_done) begin
                    if (!wr_q) begin
                        mem_out_d = dm_rdata;
                    end else begin
                        mem_out_d = mem_out_q;
                    end
                    state_d = ST_DONE;
                end else if (ctr_expire_s) begin
                    state_d     = ST_ERR;
                    err_cause_d = ERR_TIMEOUT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d     = ST_IDLE;
                err_cause_d = ERR_NONE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        dm_en_d     = (state_d == ST_REQ);
        dm_wr_d     = (state_d == ST_REQ) && wr_d;
        mem_valid_d = (state_d == ST_DONE);
        mem_busy_d  = (state_d == ST_REQ) || (state_d == ST_WAIT) ||
                      (state_d == ST_ERR) || (state_d == ST_HALT);
        mem_err_d   = (err_cause_d != ERR_NONE);
        halted_d    = (state_d == ST_HALT);
    end

    // State, operand and output registers; reset abandons any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            err_cause_q <= ERR_NONE;
            addr_q      <= {DW{1'b0}};
            wdata_q     <= {DW{1'b0}};
            wr_q        <= 1'b0;
            mem_out_q   <= {DW{1'b0}};
            dm_en_q     <= 1'b0;
            dm_wr_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_busy_q  <= 1'b0;
            mem_err_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_cause_q <= err_cause_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            mem_out_q   <= mem_out_d;
            dm_en_q     <= dm_en_d;
            dm_wr_q     <= dm_wr_d;
            mem_valid_q <= mem_valid_d;
            mem_busy_q  <= mem_busy_d;
            mem_err_q   <= mem_err_d;
            halted_q    <= halted_d;
        end
    end

    assign dm_addr   = addr_q;
    assign dm_wdata  = wdata_q;
    assign dm_en     = dm_en_q;
    assign dm_wr     = dm_wr_q;
    assign mem_out   = mem_out_q;
    assign mem_valid = mem_valid_q;
    assign mem_busy  = mem_busy_q;
    assign mem_err   = mem_err_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single-instruction vectors
// plus hand-written sequences for stall, timeout, error and reset corners.
module tb_mem_access_ctrl;

    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk;
    logic          rst;
    logic          ex_valid;
    logic [DW-1:0] ex_out;
    logic [DW-1:0] st_data;
    logic          mem_rd;
    logic          mem_wr;
    logic          halt;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_en;
    logic          dm_wr;
    logic [DW-1:0] dm_rdata;
    logic          dm_stall;
    logic          dm_done;
    logic [DW-1:0] mem_out;
    logic          mem_valid;
    logic          mem_busy;
    logic          mem_err;
    logic          halted;

    int total;
    int bad;

    mem_access_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_out    (ex_out),
        .st_data   (st_data),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .halt      (halt),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_en     (dm_en),
        .dm_wr     (dm_wr),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .dm_done   (dm_done),
        .mem_out   (mem_out),
        .mem_valid (mem_valid),
        .mem_busy  (mem_busy),
        .mem_err   (mem_err),
        .halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [DW-1:0] ex_out;
        logic [DW-1:0] st_data;
        logic [DW-1:0] rdata;
        logic [DW-1:0] exp_out;
        logic          rd;
        logic          wr;
        logic          hlt;
        logic          exp_req;
        logic          exp_valid;
        logic          exp_err;
        logic          exp_halt;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic [DW-1:0] e, input logic [DW-1:0] s,
                                input logic r, input logic w, input logic h,
                                input logic [DW-1:0] rd_data,
                                input logic req, input logic vld, input logic er,
                                input logic hl, input logic [DW-1:0] out);
        vec_t v;
        v.ex_out    = e;
        v.st_data   = s;
        v.rd        = r;
        v.wr        = w;
        v.hlt       = h;
        v.rdata     = rd_data;
        v.exp_req   = req;
        v.exp_valid = vld;
        v.exp_err   = er;
        v.exp_halt  = hl;
        v.exp_out   = out;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 1'b0;
        ex_out   = 16'h0000;
        st_data  = 16'h0000;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        halt     = 1'b0;
        dm_rdata = 16'h0000;
        dm_stall = 1'b0;
        dm_done  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dm_addr"},   dm_addr,   16'h0000);
        chk({tag, "_dm_wdata"},  dm_wdata,  16'h0000);
        chk({tag, "_dm_en"},     {15'd0, dm_en},     16'h0000);
        chk({tag, "_dm_wr"},     {15'd0, dm_wr},     16'h0000);
        chk({tag, "_mem_out"},   mem_out,   16'h0000);
        chk({tag, "_mem_valid"}, {15'd0, mem_valid}, 16'h0000);
        chk({tag, "_mem_busy"},  {15'd0, mem_busy},  16'h0000);
        chk({tag, "_mem_err"},   {15'd0, mem_err},   16'h0000);
        chk({tag, "_halted"},    {15'd0, halted},    16'h0000);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic issue(input logic [DW-1:0] e, input logic [DW-1:0] s,
                         input logic r, input logic w, input logic h);
        ex_valid = 1'b1;
        ex_out   = e;
        st_data  = s;
        mem_rd   = r;
        mem_wr   = w;
        halt     = h;
    endtask

    task automatic drop_issue();
        ex_valid = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        halt     = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();

        tbl[0] = mk(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
        tbl[1] = mk(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
        tbl[2] = mk(16'h0010, 16'h00FF, 1'b0, 1'b1, 1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tbl[3] = mk(16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tbl[4] = mk(16'h0005, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tbl[5] = mk(16'h0002, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tbl[6] = mk(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        tbl[7] = mk(16'h0003, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        tbl[8] = mk(16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0007);
        tbl[9] = mk(16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001);

        // Reset state.
        step();
        rst = 1'b1;
        do_reset();
        chk_all_zero("reset");

        // Table-driven single instructions, each from a fresh reset.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            issue(tbl[i].ex_out, tbl[i].st_data, tbl[i].rd, tbl[i].wr, tbl[i].hlt);
            step();
            drop_issue();
            chk($sformatf("v%0d_dm_en", i), {15'd0, dm_en}, {15'd0, tbl[i].exp_req});
            chk($sformatf("v%0d_mem_err", i), {15'd0, mem_err}, {15'd0, tbl[i].exp_err});
            chk($sformatf("v%0d_halted", i), {15'd0, halted}, {15'd0, tbl[i].exp_halt});
            chk($sformatf("v%0d_busy", i), {15'd0, mem_busy},
                {15'd0, tbl[i].exp_req | tbl[i].exp_err | tbl[i].exp_halt});
            if (tbl[i].exp_req) begin
                chk($sformatf("v%0d_dm_addr", i), dm_addr, tbl[i].ex_out);
                chk($sformatf("v%0d_dm_wdata", i), dm_wdata, tbl[i].st_data);
                chk($sformatf("v%0d_dm_wr", i), {15'd0, dm_wr}, {15'd0, tbl[i].wr});
                dm_done  = 1'b1;
                dm_rdata = tbl[i].rdata;
                step();
                dm_done  = 1'b0;
                chk($sformatf("v%0d_dm_en_off", i), {15'd0, dm_en}, 16'h0000);
            end else begin
                chk($sformatf("v%0d_no_req", i), {15'd0, dm_en}, 16'h0000);
            end
            chk($sformatf("v%0d_mem_valid", i), {15'd0, mem_valid}, {15'd0, tbl[i].exp_valid});
            chk($sformatf("v%0d_mem_out", i), mem_out, tbl[i].exp_out);
            step();
            chk($sformatf("v%0d_valid_once", i), {15'd0, mem_valid}, 16'h0000);
            chk($sformatf("v%0d_err_sticky", i), {15'd0, mem_err}, {15'd0, tbl[i].exp_err});
            chk($sformatf("v%0d_halt_sticky", i), {15'd0, halted}, {15'd0, tbl[i].exp_halt});
        end

        // Store with three stall cycles, done two cycles after acceptance;
        // mem_out must keep the earlier pass-through value.
        do_reset();
        issue(16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        drop_issue();
        step();
        issue(16'h0010, 16'h00FF, 1'b0, 1'b1, 1'b0);
        dm_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            drop_issue();
            chk($sformatf("st_k%0d_dm_en", k), {15'd0, dm_en}, 16'h0001);
            chk($sformatf("st_k%0d_addr", k), dm_addr, 16'h0010);
            chk($sformatf("st_k%0d_wdata", k), dm_wdata, 16'h00FF);
            chk($sformatf("st_k%0d_wr", k), {15'd0, dm_wr}, 16'h0001);
            chk($sformatf("st_k%0d_busy", k), {15'd0, mem_busy}, 16'h0001);
            if (k == 3) dm_stall = 1'b0;
        end
        step();
        chk("st_wait_dm_en", {15'd0, dm_en}, 16'h0000);
        chk("st_wait_dm_wr", {15'd0, dm_wr}, 16'h0000);
        chk("st_wait_addr_hold", dm_addr, 16'h0010);
        chk("st_wait_busy", {15'd0, mem_busy}, 16'h0001);
        step();
        chk("st_wait2_busy", {15'd0, mem_busy}, 16'h0001);
        dm_done = 1'b1;
        step();
        dm_done = 1'b0;
        chk("st_done_valid", {15'd0, mem_valid}, 16'h0001);
        chk("st_done_busy", {15'd0, mem_busy}, 16'h0000);
        chk("st_mem_out_kept", mem_out, 16'h5A5A);
        step();
        chk("st_valid_once", {15'd0, mem_valid}, 16'h0000);

        // Misaligned load: ERR, then later ex_valid and dm_done are ignored.
        do_reset();
        issue(16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        drop_issue();
        chk("mis_err", {15'd0, mem_err}, 16'h0001);
        chk("mis_no_req", {15'd0, dm_en}, 16'h0000);
        issue(16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0);
        dm_done = 1'b1;
        step();
        drop_issue();
        dm_done = 1'b0;
        step();
        chk("mis_ignore_valid", {15'd0, mem_valid}, 16'h0000);
        chk("mis_ignore_out", mem_out, 16'h0000);
        chk("mis_err_sticky", {15'd0, mem_err}, 16'h0001);
        chk("mis_busy", {15'd0, mem_busy}, 16'h0001);
        do_reset();
        chk("mis_reset_clears", {15'd0, mem_err}, 16'h0000);

        // Timeout: no dm_done, error exactly TIMEOUT cycles after WAIT entry.
        do_reset();
        issue(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        drop_issue();
        step();
        chk("to_wait_entry_en", {15'd0, dm_en}, 16'h0000);
        for (int n = 1; n < TIMEOUT; n++) begin
            step();
            chk($sformatf("to_c%0d_no_err", n), {15'd0, mem_err}, 16'h0000);
        end
        step();
        chk("to_err_at_limit", {15'd0, mem_err}, 16'h0001);
        chk("to_err_busy", {15'd0, mem_busy}, 16'h0001);
        chk("to_err_no_valid", {15'd0, mem_valid}, 16'h0000);

        // dm_done on the final count cycle completes instead of erroring.
        do_reset();
        issue(16'h0022, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        drop_issue();
        step();
        for (int n = 1; n < TIMEOUT; n++) begin
            step();
        end
        dm_done  = 1'b1;
        dm_rdata = 16'hCAFE;
        step();
        dm_done  = 1'b0;
        chk("late_done_no_err", {15'd0, mem_err}, 16'h0000);
        chk("late_done_valid", {15'd0, mem_valid}, 16'h0001);
        chk("late_done_out", mem_out, 16'hCAFE);

        // Reset mid-WAIT, late dm_done ignored, then HALT.
        do_reset();
        issue(16'h0030, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        drop_issue();
        step();
        step();
        chk("rw_in_wait_busy", {15'd0, mem_busy}, 16'h0001);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_all_zero("rw_reset");
        dm_done  = 1'b1;
        dm_rdata = 16'h9999;
        step();
        dm_done  = 1'b0;
        chk("rw_late_valid", {15'd0, mem_valid}, 16'h0000);
        chk("rw_late_out", mem_out, 16'h0000);
        chk("rw_late_busy", {15'd0, mem_busy}, 16'h0000);
        issue(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        drop_issue();
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("halt_c%0d_halted", n), {15'd0, halted}, 16'h0001);
            chk($sformatf("halt_c%0d_busy", n), {15'd0, mem_busy}, 16'h0001);
            chk($sformatf("halt_c%0d_no_req", n), {15'd0, dm_en}, 16'h0000);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-access stage directly downstream of the execute block.
- Consumes the execute result as a data address (or pass-through value), the store data and the load/store/halt controls.
- Runs a multi-cycle request/done handshake with the data memory, stalls the front end while busy, and returns the value destined for writeback.
- Also detects misaligned, conflicting and timed-out accesses.

Parameters:
DW, 16, data/address width (word-addressed; bit 0 must be 0 for memory ops)
TIMEOUT, 15, maximum cycles spent in WAIT before declaring an error
CNT_W, 4, width of the wait counter (must satisfy 2^CNT_W > TIMEOUT)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-low (asserted when 0)
ex_valid  in  1  execute result valid this cycle (one-cycle strobe per instruction)
ex_out  in  DW  execute result: address for memory ops, else pass-through value
st_data  in  DW  store data (second source register)
mem_rd  in  1  instruction is a load
mem_wr  in  1  instruction is a store
halt  in  1  instruction is HALT
dm_addr  out  DW  data memory address
dm_wdata  out  DW  data memory write data
dm_en  out  1  memory request strobe
dm_wr  out  1  1 = write, 0 = read; qualified by dm_en
dm_rdata  in  DW  memory read data, valid with dm_done
dm_stall  in  1  memory refuses the request this cycle (retry)
dm_done  in  1  access complete
mem_out  out  DW  writeback value (load data or pass-through)
mem_valid  out  1  one-cycle pulse: mem_out valid / instruction retired
mem_busy  out  1  front-end stall (hold PC, do not issue ex_valid)
mem_err  out  1  sticky error flag
halted  out  1  sticky halt flag

Behaviour:
- States: IDLE, REQ, WAIT, DONE, ERR, HALT. All state and outputs are registered.
- Reset (rst=0 at a clock edge) from any state, including mid-access:
  - state goes to IDLE.
  - All outputs go to 0; mem_out = 16'h0000.
  - The wait counter goes to 0.
  - An outstanding memory access is abandoned; a dm_done arriving afterwards is ignored.
- IDLE, while ex_valid=1 (priority order):
  - halt=1 → HALT.
  - mem_rd & mem_wr both 1 → ERR.
  - (mem_rd|mem_wr) & ex_out[0]=1 → ERR (misaligned).
  - mem_rd|mem_wr → capture ex_out, st_data and mem_wr into internal registers; → REQ.
  - Otherwise → capture ex_out into mem_out; → DONE (pass-through latency 1 cycle).
- IDLE with ex_valid=0: remain in IDLE.
- REQ:
  - dm_en=1; dm_addr, dm_wdata and dm_wr driven from the captured registers; mem_busy=1.
  - dm_stall=1: stay in REQ, re-asserting the identical request.
  - dm_stall=0 & dm_done=1: complete in the same cycle (load captures dm_rdata into mem_out; store leaves mem_out unchanged) → DONE.
  - dm_stall=0 & dm_done=0: → WAIT, clear the counter.
- WAIT:
  - dm_en=0; mem_busy=1; the counter increments each cycle.
  - dm_done=1 → capture as in REQ → DONE. dm_done takes priority over timeout in the same cycle.
  - Counter reaches TIMEOUT with no dm_done → ERR.
- DONE: mem_valid=1 for exactly one cycle; mem_busy=0; → IDLE. A new ex_valid in DONE is ignored (protocol violation).
- ERR: mem_err=1, mem_busy=1, mem_valid=0. Terminal until reset; all inputs ignored.
- HALT: halted=1, mem_busy=1. Terminal until reset; no memory requests issued.
- Outside REQ: dm_en=0, dm_wr=0; dm_addr and dm_wdata hold their last values.
- ex_valid outside IDLE is ignored; the bench flags it as a protocol error.

Decomposition:
- Shared package mem_stage_pkg:
  - state enum (IDLE, REQ, WAIT, DONE, ERR, HALT)
  - DW and default TIMEOUT constants
  - error-cause encoding (MISALIGN, CONFLICT, TIMEOUT) for the debug trace
- Sub-module mem_wait_ctr: CNT_W-bit counter with clear/enable inputs and an expire output at TIMEOUT. Instantiated once.

Test Plan:
- Pass-through: ex_valid with ex_out=16'h1234, mem_rd=mem_wr=0 → next cycle mem_out=16'h1234, mem_valid=1 for one cycle, dm_en never asserted.
- Load, zero-stall memory: ex_out=16'h0040; dm_done=1 with dm_rdata=16'hBEEF in the REQ cycle → dm_en=1, dm_wr=0, dm_addr=16'h0040 for one cycle; mem_valid in the following cycle with mem_out=16'hBEEF.
- Store with dm_stall high for 3 cycles, then dm_done 2 cycles after acceptance; ex_out=16'h0010, st_data=16'h00FF:
  - dm_en=1 for 4 consecutive cycles with a stable request;
  - mem_busy high throughout;
  - mem_valid pulses once; mem_out unchanged.
- Misaligned access: mem_rd=1, ex_out=16'h0003 → ERR next cycle, mem_err=1, no dm_en. A subsequent ex_valid has no effect until rst=0.
- Timeout: load accepted, dm_done never arrives → mem_err=1 exactly TIMEOUT cycles after entering WAIT. Separately, dm_done on the final count cycle → DONE, not ERR.
- Reset mid-WAIT, then HALT:
  - rst=0 during WAIT → IDLE; all outputs 0; a late dm_done is ignored.
  - Next, ex_valid with halt=1 → halted=1, mem_busy=1 held.
